// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: EX/WB forwarding selects, load-use stall and bubble, saturating stall counter
module hazard_forward_ctrl #(
   parameter int AW      = 5,
   parameter bit R0_HARD = 1'b1,
   parameter int CNT_W   = 16
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [AW-1:0]    AA,
   input  logic [AW-1:0]    BA,
   input  logic             MA,
   input  logic             MB,
   input  logic [AW-1:0]    DA,
   input  logic             RW,
   input  logic             LD,
   input  logic             FLUSH,
   output logic             EX_Hazard_A,
   output logic             WB_Hazard_A,
   output logic             EX_Hazard_B,
   output logic             WB_Hazard_B,
   output logic             Stall,
   output logic [CNT_W-1:0] Stall_Cnt
);
   logic [AW-1:0]    da_ex_q, da_ex_d, da_wb_q, da_wb_d;
   logic             rw_ex_q, rw_ex_d, ld_ex_q, ld_ex_d, rw_wb_q, rw_wb_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             ex_ok, wb_ok, m_ex_a, m_ex_b, m_wb_a, m_wb_b;
   always_comb begin
      ex_ok       = rw_ex_q && !(R0_HARD && da_ex_q == '0);
      wb_ok       = rw_wb_q && !(R0_HARD && da_wb_q == '0);
      m_ex_a      = ex_ok && da_ex_q == AA;
      m_ex_b      = ex_ok && da_ex_q == BA;
      m_wb_a      = wb_ok && da_wb_q == AA;
      m_wb_b      = wb_ok && da_wb_q == BA;
      Stall       = !FLUSH && ld_ex_q && ((m_ex_a && !MA) || (m_ex_b && !MB));
      EX_Hazard_A = m_ex_a && !MA && !ld_ex_q;
      EX_Hazard_B = m_ex_b && !MB && !ld_ex_q;
      WB_Hazard_A = m_wb_a && !MA;
      WB_Hazard_B = m_wb_b && !MB;
      Stall_Cnt   = stall_cnt_q;
      da_wb_d     = da_ex_q;
      rw_wb_d     = rw_ex_q;
      // a flushed or stalled ID instruction enters EX as a bubble
      da_ex_d     = (FLUSH || Stall) ? '0 : DA;
      rw_ex_d     = (FLUSH || Stall) ? 1'b0 : RW;
      ld_ex_d     = (FLUSH || Stall) ? 1'b0 : LD;
      stall_cnt_d = (Stall && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
   end
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         da_ex_q     <= '0;
         rw_ex_q     <= 1'b0;
         ld_ex_q     <= 1'b0;
         da_wb_q     <= '0;
         rw_wb_q     <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         da_ex_q     <= da_ex_d;
         rw_ex_q     <= rw_ex_d;
         ld_ex_q     <= ld_ex_d;
         da_wb_q     <= da_wb_d;
         rw_wb_q     <= rw_wb_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: directed vectors for forwarding, load-use stall, R0, flush, reset, saturation
module tb_hazard_forward_ctrl;
   localparam int AW    = 5;
   localparam int CNT_W = 2;
   logic             CLK = 1'b0;
   logic             RESET_N;
   logic [AW-1:0]    AA, BA, DA;
   logic             MA, MB, RW, LD, FLUSH;
   logic             EX_Hazard_A, WB_Hazard_A, EX_Hazard_B, WB_Hazard_B, Stall;
   logic [CNT_W-1:0] Stall_Cnt;
   int               checks = 0;
   int               failures = 0;

   hazard_forward_ctrl #(.AW(AW), .R0_HARD(1'b1), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .AA(AA), .BA(BA), .MA(MA), .MB(MB),
      .DA(DA), .RW(RW), .LD(LD), .FLUSH(FLUSH),
      .EX_Hazard_A(EX_Hazard_A), .WB_Hazard_A(WB_Hazard_A),
      .EX_Hazard_B(EX_Hazard_B), .WB_Hazard_B(WB_Hazard_B),
      .Stall(Stall), .Stall_Cnt(Stall_Cnt)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic id_in(input int aa, input bit ma, input int ba, input bit mb,
                        input int da, input bit rw, input bit ld, input bit fl);
      AA = AW'(aa); MA = ma; BA = AW'(ba); MB = mb;
      DA = AW'(da); RW = rw; LD = ld; FLUSH = fl;
      #1;
   endtask

   task automatic idle();
      id_in(0, 1, 0, 1, 0, 0, 0, 0);
   endtask

   initial begin
      RESET_N = 1'b0;
      idle();
      check("rst_stall", Stall, 0);
      check("rst_cnt", Stall_Cnt, 0);
      tick(); tick();
      RESET_N = 1'b1;
      // EX forward, then WB forward a cycle later
      id_in(0, 1, 0, 1, 3, 1, 0, 0); tick();
      id_in(0, 1, 3, 0, 0, 0, 0, 0);
      check("exf_exb", EX_Hazard_B, 1);
      check("exf_wbb", WB_Hazard_B, 0);
      check("exf_stall", Stall, 0);
      check("exf_exa", EX_Hazard_A, 0);
      tick();
      check("wbf_wbb", WB_Hazard_B, 1);
      check("wbf_exb", EX_Hazard_B, 0);
      // both stages hold r5
      id_in(0, 1, 0, 1, 5, 1, 0, 0); tick(); tick();
      id_in(0, 1, 5, 0, 0, 0, 0, 0);
      check("dbl_exb", EX_Hazard_B, 1);
      check("dbl_wbb", WB_Hazard_B, 1);
      id_in(5, 1, 5, 1, 0, 0, 0, 0);
      check("dbl_mb_exb", EX_Hazard_B, 0);
      check("dbl_mb_wbb", WB_Hazard_B, 0);
      check("dbl_ma_exa", EX_Hazard_A, 0);
      id_in(5, 0, 0, 1, 0, 0, 0, 0);
      check("dbl_a_exa", EX_Hazard_A, 1);
      check("dbl_a_wba", WB_Hazard_A, 1);
      idle(); tick(); tick();
      // load-use: one stall, then WB forward only
      check("lu_cnt0", Stall_Cnt, 0);
      id_in(0, 1, 0, 1, 7, 1, 1, 0); tick();
      id_in(7, 0, 0, 1, 0, 0, 0, 0);
      check("lu_stall", Stall, 1);
      check("lu_exa", EX_Hazard_A, 0);
      check("lu_cnt_pre", Stall_Cnt, 0);
      tick();
      check("lu_cnt1", Stall_Cnt, 1);
      check("lu_stall2", Stall, 0);
      check("lu_wba", WB_Hazard_A, 1);
      check("lu_exa2", EX_Hazard_A, 0);
      idle(); tick(); tick();
      // register 0 never forwarded
      id_in(0, 1, 0, 1, 0, 1, 0, 0); tick();
      id_in(0, 0, 0, 0, 0, 0, 0, 0);
      check("r0_exa", EX_Hazard_A, 0);
      check("r0_exb", EX_Hazard_B, 0);
      tick();
      check("r0_wbb", WB_Hazard_B, 0);
      // flush suppresses the stall and bubbles EX despite RW in ID
      id_in(0, 1, 0, 1, 7, 1, 1, 0); tick();
      id_in(7, 0, 0, 1, 9, 1, 0, 1);
      check("fl_stall", Stall, 0);
      check("fl_exa", EX_Hazard_A, 0);
      tick();
      id_in(9, 0, 7, 0, 0, 0, 0, 0);
      check("fl_bub_exa", EX_Hazard_A, 0);
      check("fl_bub_wba", WB_Hazard_A, 0);
      check("fl_wbb", WB_Hazard_B, 1);
      check("fl_cnt", Stall_Cnt, 1);
      idle(); tick(); tick();
      // async reset mid-stream with live tags
      id_in(0, 1, 0, 1, 4, 1, 0, 0); tick();
      id_in(0, 1, 0, 1, 7, 1, 1, 0); tick();
      id_in(7, 0, 4, 0, 0, 0, 0, 0);
      check("mrst_pre_stall", Stall, 1);
      check("mrst_pre_wbb", WB_Hazard_B, 1);
      RESET_N = 1'b0;
      #1;
      check("mrst_stall", Stall, 0);
      check("mrst_wbb", WB_Hazard_B, 0);
      check("mrst_exa", EX_Hazard_A, 0);
      check("mrst_cnt", Stall_Cnt, 0);
      #2 RESET_N = 1'b1;
      tick();
      check("mrst_stale_wbb", WB_Hazard_B, 0);
      check("mrst_stale_stall", Stall, 0);
      // saturation with a 2-bit counter
      for (int i = 0; i < 5; i++) begin
         id_in(0, 1, 0, 1, 7, 1, 1, 0); tick();
         id_in(0, 1, 7, 0, 0, 0, 0, 0);
         check("sat_stall", Stall, 1);
         tick();
         check("sat_cnt", Stall_Cnt, (i + 1 > 3) ? 3 : i + 1);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
